// File: rtl/spike_rate_encoder_if.sv
// Spike encoder control/observation bundle.
// master drives en/rate; slave is the encoder.
interface spike_rate_encoder_if;
    logic       en;
    logic [7:0] rate;
    logic       spike;
    logic [1:0] state;
    logic [7:0] counter;
    logic [7:0] spike_count;
    logic       window_done;

    modport master (
        output en,
        output rate,
        input  spike,
        input  state,
        input  counter,
        input  spike_count,
        input  window_done
    );

    modport slave (
        input  en,
        input  rate,
        output spike,
        output state,
        output counter,
        output spike_count,
        output window_done
    );
endinterface

// File: rtl/spike_rate_encoder.sv
// Rate-to-spike encoder with refractory hold-off and windowed tally.
// SPIKE_LFSR_EN selects stochastic (LFSR) firing instead of the accumulator.
module spike_rate_encoder #(
    parameter int unsigned REFRACT   = 2,
    parameter int unsigned WIN_BITS  = 4,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input logic            clk,
    input logic            rst,
    spike_rate_encoder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        REFR = 2'd2
    } state_t;

    localparam logic [3:0] R_LOAD =
        (REFRACT == 0) ? 4'd0 : 4'(REFRACT - 1);
    localparam logic [WIN_BITS-1:0] WIN_ONE = 1;

    if (REFRACT > 15) begin : g_bad_refract
        $error("REFRACT out of range");
    end
    if (WIN_BITS < 1 || WIN_BITS > 8) begin : g_bad_win
        $error("WIN_BITS out of range");
    end
    if (LFSR_SEED == 8'h00) begin : g_bad_seed
        $error("LFSR_SEED must be non-zero");
    end

    state_t              st;
    logic [7:0]          acc;
    logic [WIN_BITS-1:0] win_cnt;
    logic [7:0]          tally;
    logic [3:0]          rcnt;
    logic                spike_q;
    logic                wd_q;
    logic [7:0]          sc_q;

    logic                fire;
    logic [7:0]          acc_nxt;
    logic [7:0]          tally_nxt;
    logic                win_last;

`ifdef SPIKE_LFSR_EN
    logic [7:0] lfsr;
    logic [7:0] lfsr_nxt;

    // Right-shift Galois form of x^8+x^6+x^5+x^4+1.
    always_comb begin
        lfsr_nxt = {1'b0, lfsr[7:1]};
        if (lfsr[0])
            lfsr_nxt = lfsr_nxt ^ 8'hB8;
    end

    always_comb begin
        fire    = (st == RUN) && (lfsr < bus.rate);
        acc_nxt = 8'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr <= LFSR_SEED;
        else if (st == RUN && bus.en)
            lfsr <= lfsr_nxt;
    end
`else
    logic [8:0] sum;

    always_comb begin
        sum     = {1'b0, acc} + {1'b0, bus.rate};
        fire    = (st == RUN) && sum[8];
        acc_nxt = sum[7:0];
    end
`endif

    always_comb begin
        tally_nxt = (tally == 8'hFF) ? 8'hFF
                                     : tally + {7'b0, fire};
        win_last  = &win_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= IDLE;
            acc     <= 8'h00;
            win_cnt <= '0;
            tally   <= 8'h00;
            rcnt    <= 4'd0;
            spike_q <= 1'b0;
            wd_q    <= 1'b0;
            sc_q    <= 8'h00;
        end else begin
            spike_q <= 1'b0;
            wd_q    <= 1'b0;
            if (!bus.en || st == IDLE) begin
                // Entering RUN also starts from a clean window.
                st      <= bus.en ? RUN : IDLE;
                acc     <= 8'h00;
                win_cnt <= '0;
                tally   <= 8'h00;
                rcnt    <= 4'd0;
            end else begin
                win_cnt <= win_cnt + WIN_ONE;
                if (win_last) begin
                    sc_q  <= tally_nxt;
                    tally <= 8'h00;
                    wd_q  <= 1'b1;
                end else begin
                    tally <= tally_nxt;
                end
                unique case (st)
                    RUN: begin
                        acc     <= acc_nxt;
                        spike_q <= fire;
                        if (fire && REFRACT != 0) begin
                            st   <= REFR;
                            rcnt <= R_LOAD;
                        end
                    end
                    REFR: begin
                        if (rcnt == 4'd0)
                            st <= RUN;
                        else
                            rcnt <= rcnt - 4'd1;
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

    assign bus.spike       = spike_q;
    assign bus.state       = st;
    assign bus.counter     = 8'(win_cnt);
    assign bus.spike_count = sc_q;
    assign bus.window_done = wd_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Scoreboard bench for spike_rate_encoder (REFRACT=0 and REFRACT=2 copies).
// Expected outputs come from a cycle model pushed on each clock edge.
module tb_spike_rate_encoder;

    localparam int WB   = 4;
    localparam int WLEN = 1 << WB;

    typedef struct packed {
        int       st;
        int       acc;
        int       cnt;
        int       tally;
        int       rr;
        bit       spike;
        int       sc;
        bit       wd;
        bit [7:0] lfsr;
    } mdl_t;

    typedef logic [19:0] obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] rate;

    int n_chk  = 0;
    int n_fail = 0;

    mdl_t m0, m2;
    obs_t q0[$];
    obs_t q2[$];
    obs_t e0, e2;

    always #5 clk = ~clk;

    spike_rate_encoder_if if0 ();
    spike_rate_encoder_if if2 ();

    assign if0.en   = en;
    assign if0.rate = rate;
    assign if2.en   = en;
    assign if2.rate = rate;

    spike_rate_encoder #(
        .REFRACT(0), .WIN_BITS(WB), .LFSR_SEED(8'hA5)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(if0)
    );

    spike_rate_encoder #(
        .REFRACT(2), .WIN_BITS(WB), .LFSR_SEED(8'hA5)
    ) dut2 (
        .clk(clk), .rst(rst), .bus(if2)
    );

    function automatic mdl_t mreset();
        mdl_t m;
        m = '0;
        m.lfsr = 8'hA5;
        return m;
    endfunction

    function automatic bit [7:0] lfsr_adv(input bit [7:0] l);
        bit b;
        b = l[0];
        l = l >> 1;
        if (b) l = l ^ 8'b1011_1000;
        return l;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input bit e,
                                   input bit [7:0] r, input int refr);
        mdl_t n;
        int   s, t;
        bit   fire;
        n = m;
        fire = 1'b0;
        n.spike = 1'b0;
        n.wd = 1'b0;
        if (!e || m.st == 0) begin
            n.st = e ? 1 : 0;
            n.acc = 0;
            n.cnt = 0;
            n.tally = 0;
            n.rr = 0;
            return n;
        end
        if (m.st == 1) begin
`ifdef SPIKE_LFSR_EN
            fire = (m.lfsr < r);
            n.lfsr = lfsr_adv(m.lfsr);
`else
            s = m.acc + int'(r);
            fire = (s > 255);
            n.acc = s % 256;
`endif
            if (fire && refr > 0) begin
                n.st = 2;
                n.rr = refr;
            end
        end else begin
            n.rr = m.rr - 1;
            if (n.rr == 0) n.st = 1;
        end
        n.spike = fire;
        t = m.tally + (fire ? 1 : 0);
        if (t > 255) t = 255;
        if (m.cnt == WLEN - 1) begin
            n.sc = t;
            n.tally = 0;
            n.wd = 1'b1;
            n.cnt = 0;
        end else begin
            n.tally = t;
            n.cnt = m.cnt + 1;
        end
        return n;
    endfunction

    function automatic obs_t pk(input mdl_t m);
        return {m.spike, m.st[1:0], m.cnt[7:0], m.sc[7:0], m.wd};
    endfunction

    function automatic obs_t get0();
        return {if0.spike, if0.state, if0.counter,
                if0.spike_count, if0.window_done};
    endfunction

    function automatic obs_t get2();
        return {if2.spike, if2.state, if2.counter,
                if2.spike_count, if2.window_done};
    endfunction

    // One clock edge: advance both models, queue their outputs.
    task automatic tick();
        @(posedge clk);
        m0 = mstep(m0, en, rate, 0);
        m2 = mstep(m2, en, rate, 2);
        q0.push_back(pk(m0));
        q2.push_back(pk(m2));
        @(negedge clk);
        e0 = q0.pop_front();
        e2 = q2.pop_front();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        en   = 1'b0;
        rate = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        m0 = mreset();
        m2 = mreset();
        q0.delete();
        q2.delete();
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        en   = 1'b0;
        rate = 8'd77;
        @(negedge clk);
        n_chk += 2;
        if (get0() !== 20'h0) begin
            n_fail++;
            $display("FAIL reset dut0 got %h exp %h", get0(), 20'h0);
        end
        if (get2() !== 20'h0) begin
            n_fail++;
            $display("FAIL reset dut2 got %h exp %h", get2(), 20'h0);
        end
        rst = 1'b0;
        m0 = mreset();
        m2 = mreset();
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk += 2;
            if (get0() !== e0) begin
                n_fail++;
                $display("FAIL idle dut0 k=%0d got %h exp %h", k, get0(), e0);
            end
            if (get2() !== e2) begin
                n_fail++;
                $display("FAIL idle dut2 k=%0d got %h exp %h", k, get2(), e2);
            end
        end
    endtask

    task automatic test_rate128();
        do_reset();
        en   = 1'b1;
        rate = 8'd128;
        for (int k = 0; k <= 20; k++) begin
            tick();
            n_chk += 2;
            if (get0() !== e0) begin
                n_fail++;
                $display("FAIL r128 dut0 k=%0d got %h exp %h", k, get0(), e0);
            end
            if (get2() !== e2) begin
                n_fail++;
                $display("FAIL r128 dut2 k=%0d got %h exp %h", k, get2(), e2);
            end
            if (k == 0) begin
                n_chk++;
                if (if0.state !== 2'd1) begin
                    n_fail++;
                    $display("FAIL r128 enter got %0d exp 1", if0.state);
                end
            end
            if (k >= 1 && k <= 16) begin
                n_chk++;
                if (if0.spike !== ((k % 2) == 0)) begin
                    n_fail++;
                    $display("FAIL r128 spike k=%0d got %b exp %b",
                             k, if0.spike, (k % 2) == 0);
                end
            end
            if (k == 16) begin
                n_chk++;
                if ({if0.window_done, if0.spike_count} !== {1'b1, 8'd8}) begin
                    n_fail++;
                    $display("FAIL r128 window got wd=%b sc=%0d exp wd=1 sc=8",
                             if0.window_done, if0.spike_count);
                end
            end
        end
    endtask

    task automatic test_refract();
        bit       xs;
        bit [1:0] xst;
        do_reset();
        en   = 1'b1;
        rate = 8'd255;
        for (int k = 0; k <= 12; k++) begin
            tick();
            n_chk += 4;
            if (get0() !== e0) begin
                n_fail++;
                $display("FAIL refr dut0 k=%0d got %h exp %h", k, get0(), e0);
            end
            if (get2() !== e2) begin
                n_fail++;
                $display("FAIL refr dut2 k=%0d got %h exp %h", k, get2(), e2);
            end
            xs = (k == 2 || k == 5 || k == 8 || k == 11);
            if (if2.spike !== xs) begin
                n_fail++;
                $display("FAIL refr spike k=%0d got %b exp %b", k, if2.spike, xs);
            end
            if (if0.spike !== (k >= 2)) begin
                n_fail++;
                $display("FAIL r255 spike k=%0d got %b exp %b",
                         k, if0.spike, k >= 2);
            end
            if (k >= 1 && k <= 4) begin
                xst = (k == 2 || k == 3) ? 2'd2 : 2'd1;
                n_chk++;
                if (if2.state !== xst) begin
                    n_fail++;
                    $display("FAIL refr state k=%0d got %0d exp %0d",
                             k, if2.state, xst);
                end
            end
        end
    endtask

    task automatic test_silent();
        bit xwd;
        do_reset();
        en   = 1'b1;
        rate = 8'd0;
        for (int k = 0; k <= 3 * WLEN; k++) begin
            tick();
            n_chk += 4;
            if (get0() !== e0) begin
                n_fail++;
                $display("FAIL zero dut0 k=%0d got %h exp %h", k, get0(), e0);
            end
            if (get2() !== e2) begin
                n_fail++;
                $display("FAIL zero dut2 k=%0d got %h exp %h", k, get2(), e2);
            end
            if ((if0.spike | if2.spike) !== 1'b0) begin
                n_fail++;
                $display("FAIL zero spike k=%0d got %b/%b exp 0",
                         k, if0.spike, if2.spike);
            end
            xwd = (k > 0) && (k % WLEN == 0);
            if ({if0.window_done, if0.spike_count} !== {xwd, 8'd0}) begin
                n_fail++;
                $display("FAIL zero window k=%0d got wd=%b sc=%0d exp wd=%b sc=0",
                         k, if0.window_done, if0.spike_count, xwd);
            end
        end
    endtask

    task automatic test_en_drop();
        do_reset();
        en   = 1'b1;
        rate = 8'd128;
        for (int k = 0; k <= 26; k++) begin
            tick();
            n_chk += 2;
            if (get0() !== e0) begin
                n_fail++;
                $display("FAIL drop dut0 k=%0d got %h exp %h", k, get0(), e0);
            end
            if (get2() !== e2) begin
                n_fail++;
                $display("FAIL drop dut2 k=%0d got %h exp %h", k, get2(), e2);
            end
        end
        en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_chk += 3;
            if (get0() !== e0) begin
                n_fail++;
                $display("FAIL drop idle dut0 k=%0d got %h exp %h", k, get0(), e0);
            end
            if (get2() !== e2) begin
                n_fail++;
                $display("FAIL drop idle dut2 k=%0d got %h exp %h", k, get2(), e2);
            end
            if (get0() !== {1'b0, 2'd0, 8'd0, 8'd8, 1'b0}) begin
                n_fail++;
                $display("FAIL drop const k=%0d got %h exp %h",
                         k, get0(), {1'b0, 2'd0, 8'd0, 8'd8, 1'b0});
            end
        end
    endtask

    task automatic test_async_reset();
        bit found;
        do_reset();
        en   = 1'b1;
        rate = 8'd255;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            tick();
            n_chk += 2;
            if (get0() !== e0) begin
                n_fail++;
                $display("FAIL arst dut0 k=%0d got %h exp %h", k, get0(), e0);
            end
            if (get2() !== e2) begin
                n_fail++;
                $display("FAIL arst dut2 k=%0d got %h exp %h", k, get2(), e2);
            end
            if (k > WLEN && if2.spike === 1'b1 && if2.state === 2'd2)
                found = 1'b1;
        end
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL arst wait got no spike in REFR exp spike in REFR");
        end
        #2;
        rst = 1'b1;
        #1;
        n_chk += 2;
        if (get2() !== 20'h0) begin
            n_fail++;
            $display("FAIL arst dut2 got %h exp %h", get2(), 20'h0);
        end
        if (get0() !== 20'h0) begin
            n_fail++;
            $display("FAIL arst dut0 got %h exp %h", get0(), 20'h0);
        end
        rst = 1'b0;
        m0 = mreset();
        m2 = mreset();
        q0.delete();
        q2.delete();
        for (int k = 0; k < 4; k++) begin
            tick();
            n_chk += 2;
            if (get0() !== e0) begin
                n_fail++;
                $display("FAIL arst post dut0 k=%0d got %h exp %h", k, get0(), e0);
            end
            if (get2() !== e2) begin
                n_fail++;
                $display("FAIL arst post dut2 k=%0d got %h exp %h", k, get2(), e2);
            end
        end
    endtask

`ifdef SPIKE_LFSR_EN
    task automatic test_lfsr();
        do_reset();
        en   = 1'b1;
        rate = 8'd255;
        for (int k = 0; k < 60; k++) begin
            if (k == 40) rate = 8'd0;
            tick();
            n_chk += 2;
            if (get0() !== e0) begin
                n_fail++;
                $display("FAIL lfsr dut0 k=%0d got %h exp %h", k, get0(), e0);
            end
            if (get2() !== e2) begin
                n_fail++;
                $display("FAIL lfsr dut2 k=%0d got %h exp %h", k, get2(), e2);
            end
            if (k > 40) begin
                n_chk++;
                if (if0.spike !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lfsr zero k=%0d got %b exp 0", k, if0.spike);
                end
            end
        end
    endtask
`endif

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            en = ($urandom_range(0, 24) != 0);
            case ($urandom_range(0, 3))
                0: rate = 8'd255;
                1: rate = 8'd0;
                default: rate = 8'($urandom_range(0, 255));
            endcase
            tick();
            n_chk += 2;
            if (get0() !== e0) begin
                n_fail++;
                $display("FAIL rand dut0 k=%0d got %h exp %h", k, get0(), e0);
            end
            if (get2() !== e2) begin
                n_fail++;
                $display("FAIL rand dut2 k=%0d got %h exp %h", k, get2(), e2);
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        rate = 8'd0;
        test_reset();
        test_rate128();
        test_refract();
        test_silent();
        test_en_drop();
        test_async_reset();
`ifdef SPIKE_LFSR_EN
        test_lfsr();
`endif
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
